// File: rtl/dfp_arb_pkg.sv
// dfp_arb_pkg: shared definitions for the DFP memory-port arbiter.
//   - dfp_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   - PORT_I/PORT_D : port indices (icache = 0, dcache = 1)
//   - LINE_W_DEF/ADDR_W_DEF : default line and address widths
package dfp_arb_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } dfp_state_e;

endpackage

// File: rtl/dfp_arb_pick.sv
// dfp_arb_pick: combinational 2-way picker for the DFP arbiter.
// Ports:
//   pending    [1:0] in  : bit0 = icache pending, bit1 = dcache pending
//   last_grant       in  : port granted most recently (PORT_I / PORT_D)
//   grant      [1:0] out : one-hot winner, 2'b00 when nothing pends
// Macro DFP_ARB_ROUND_ROBIN_EN: defined -> round-robin on ties (the port
// not granted last wins); undefined -> dcache always wins ties and
// last_grant is ignored.
module dfp_arb_pick
  import dfp_arb_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifndef DFP_ARB_ROUND_ROBIN_EN
  // Fixed priority has no history; keep the port for a uniform interface.
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Winner selection; only the tie case depends on the policy.
  always_comb begin
    grant = 2'b00;
    case (pending)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef DFP_ARB_ROUND_ROBIN_EN
        if (last_grant == PORT_D) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
`else
        grant = 2'b10;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dfp_arbiter.sv
// dfp_arbiter: shares one 256-bit memory port between the icache (port 0,
// i_dfp_*) and dcache (port 1, d_dfp_*) downstream-facing ports.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   i_dfp_* / d_dfp_*     : cache requests (addr/read/write/wdata in,
//                           rdata/resp out); requests held until resp
//   mem_addr/read/write/wdata : registered granted request to memory
//   mem_rdata, mem_resp   : memory response
// Every transaction returns through IDLE, so a new grant can start no
// earlier than two cycles after the previous mem_resp.
// Macro DFP_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see
// dfp_arb_pick); when undefined dcache wins ties and no history is kept.
module dfp_arbiter
  import dfp_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_dfp_addr,
  input  logic              i_dfp_read,
  input  logic              i_dfp_write,
  input  logic [LINE_W-1:0] i_dfp_wdata,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic              i_dfp_resp,
  input  logic [ADDR_W-1:0] d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  dfp_state_e        state_r, state_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
  logic              mem_read_r, mem_read_nxt_s;
  logic              mem_write_r, mem_write_nxt_s;
  logic [LINE_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
  logic [1:0]        pending_s, grant_s;
  logic              last_grant_s;

  assign pending_s = {d_dfp_read | d_dfp_write, i_dfp_read | i_dfp_write};

  dfp_arb_pick u_pick (
    .pending    (pending_s),
    .last_grant (last_grant_s),
    .grant      (grant_s)
  );

`ifdef DFP_ARB_ROUND_ROBIN_EN
  logic last_grant_r;

  // Remember the most recent winner; reset value makes icache win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= PORT_D;
    end else if ((state_r == IDLE) && (pending_s != 2'b00)) begin
      last_grant_r <= grant_s[PORT_D] ? PORT_D : PORT_I;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = PORT_D;
`endif

  // Next state and next memory-request registers.
  always_comb begin
    state_nxt_s     = state_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_read_nxt_s  = mem_read_r;
    mem_write_nxt_s = mem_write_r;
    mem_wdata_nxt_s = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (grant_s[PORT_I]) begin
          state_nxt_s     = BUSY_I;
          mem_addr_nxt_s  = i_dfp_addr;
          mem_wdata_nxt_s = i_dfp_wdata;
          mem_read_nxt_s  = i_dfp_read;
          // A read+write collision is illegal; the read takes the port.
          mem_write_nxt_s = i_dfp_write & ~i_dfp_read;
        end else if (grant_s[PORT_D]) begin
          state_nxt_s     = BUSY_D;
          mem_addr_nxt_s  = d_dfp_addr;
          mem_wdata_nxt_s = d_dfp_wdata;
          mem_read_nxt_s  = d_dfp_read;
          mem_write_nxt_s = d_dfp_write & ~d_dfp_read;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          state_nxt_s     = IDLE;
          mem_read_nxt_s  = 1'b0;
          mem_write_nxt_s = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
      end
    endcase
  end

  // State and memory-request registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_wdata_r <= {LINE_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_read_r  <= mem_read_nxt_s;
      mem_write_r <= mem_write_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_wdata = mem_wdata_r;

  // Read data is broadcast; only the granted port sees the completion pulse.
  assign i_dfp_rdata = mem_rdata;
  assign d_dfp_rdata = mem_rdata;
  assign i_dfp_resp  = (state_r == BUSY_I) && mem_resp;
  assign d_dfp_resp  = (state_r == BUSY_D) && mem_resp;

  dfp_arb_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .state       (state_r),
    .i_dfp_read  (i_dfp_read),
    .i_dfp_write (i_dfp_write),
    .d_dfp_read  (d_dfp_read),
    .d_dfp_write (d_dfp_write)
  );

endmodule

// dfp_arb_chk: protocol checks on the cache-side request handshake.
module dfp_arb_chk
  import dfp_arb_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input dfp_state_e state,
  input logic       i_dfp_read,
  input logic       i_dfp_write,
  input logic       d_dfp_read,
  input logic       d_dfp_write
);

  a_i_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !(i_dfp_read && i_dfp_write));
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !(d_dfp_read && d_dfp_write));
  a_i_hold: assert property (@(posedge clk) disable iff (rst)
    (state == BUSY_I) |-> (i_dfp_read || i_dfp_write));
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (state == BUSY_D) |-> (d_dfp_read || d_dfp_write));

endmodule

// File: tb/tb_dfp_arbiter.sv
// tb_dfp_arbiter: directed self-checking bench for dfp_arbiter.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_dfp_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_dfp_addr, d_dfp_addr, mem_addr;
  logic         i_dfp_read, i_dfp_write, d_dfp_read, d_dfp_write;
  logic [255:0] i_dfp_wdata, d_dfp_wdata, i_dfp_rdata, d_dfp_rdata;
  logic         i_dfp_resp, d_dfp_resp;
  logic         mem_read, mem_write, mem_resp;
  logic [255:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [255:0] pat_a5, pat_wr, pat_5a;
  logic [31:0]  first_addr, second_addr, exp_addr;
  logic         first_is_i, exp_i;

  dfp_arbiter dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_write(i_dfp_write),
    .i_dfp_wdata(i_dfp_wdata), .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_wr = {8{32'h1234_5678}};
    pat_5a = {32{8'h5A}};
    rst = 1'b1;
    i_dfp_addr = 32'h0; i_dfp_read = 1'b0; i_dfp_write = 1'b0; i_dfp_wdata = 256'h0;
    d_dfp_addr = 32'h0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = 256'h0;
    mem_rdata = 256'h0; mem_resp = 1'b0;

    // Reset state
    cyc(); cyc();
    #1;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 256'h0);
    chk("rst_i_resp", i_dfp_resp, 1'b0);
    chk("rst_d_resp", d_dfp_resp, 1'b0);

    // Test 1: icache read 0x1000, mem_resp 4 cycles after grant
    cyc(); rst = 1'b0;                                   // t=0
    i_dfp_addr = 32'h0000_1000; i_dfp_read = 1'b1;
    #1; chk("t1_t0_mem_read", mem_read, 1'b0);
    cyc(); #1;                                           // t=1
    chk("t1_mem_read", mem_read, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h0000_1000);
    chk("t1_mem_write", mem_write, 1'b0);
    cyc(); cyc(); cyc(); #1;                             // t=4
    chk("t1_hold_read", mem_read, 1'b1);
    cyc(); mem_resp = 1'b1; mem_rdata = pat_a5; #1;      // t=5
    chk("t1_i_resp", i_dfp_resp, 1'b1);
    chk("t1_i_rdata", i_dfp_rdata, pat_a5);
    chk("t1_d_rdata", d_dfp_rdata, pat_a5);
    chk("t1_d_resp", d_dfp_resp, 1'b0);
    cyc(); mem_resp = 1'b0; i_dfp_read = 1'b0; #1;       // t=6
    chk("t1_read_clr", mem_read, 1'b0);
    chk("t1_i_resp_clr", i_dfp_resp, 1'b0);

    // Test 2: dcache write 0x2020
    cyc(); d_dfp_addr = 32'h0000_2020; d_dfp_wdata = pat_wr; d_dfp_write = 1'b1; // t=0
    cyc(); #1;                                           // t=1
    chk("t2_mem_write", mem_write, 1'b1);
    chk("t2_mem_read", mem_read, 1'b0);
    chk("t2_mem_addr", mem_addr, 32'h0000_2020);
    chk("t2_mem_wdata", mem_wdata, pat_wr);
    chk("t2_i_resp_busy", i_dfp_resp, 1'b0);
    cyc(); cyc(); cyc(); mem_resp = 1'b1; #1;            // t=4
    chk("t2_d_resp", d_dfp_resp, 1'b1);
    chk("t2_i_resp", i_dfp_resp, 1'b0);
    cyc(); mem_resp = 1'b0; d_dfp_write = 1'b0; #1;      // t=5
    chk("t2_write_clr", mem_write, 1'b0);
    chk("t2_d_resp_clr", d_dfp_resp, 1'b0);

    // Test 3: simultaneous reads; second strobe exactly 2 cycles after first resp
`ifdef DFP_ARB_ROUND_ROBIN_EN
    first_is_i = 1'b1;
`else
    first_is_i = 1'b0;
`endif
    first_addr  = first_is_i ? 32'h0000_0100 : 32'h0000_0200;
    second_addr = first_is_i ? 32'h0000_0200 : 32'h0000_0100;
    cyc(); i_dfp_addr = 32'h0000_0100; d_dfp_addr = 32'h0000_0200;  // t=0
    i_dfp_read = 1'b1; d_dfp_read = 1'b1;
    cyc(); #1;                                           // t=1
    chk("t3_first_read", mem_read, 1'b1);
    chk("t3_first_addr", mem_addr, first_addr);
    cyc(); mem_resp = 1'b1; mem_rdata = pat_5a; #1;      // t=2
    chk("t3_first_i_resp", i_dfp_resp, first_is_i);
    chk("t3_first_d_resp", d_dfp_resp, !first_is_i);
    cyc(); mem_resp = 1'b0;                              // t=3
    if (first_is_i) i_dfp_read = 1'b0; else d_dfp_read = 1'b0;
    #1; chk("t3_gap_idle", mem_read, 1'b0);
    cyc(); #1;                                           // t=4
    chk("t3_second_read", mem_read, 1'b1);
    chk("t3_second_addr", mem_addr, second_addr);
    cyc(); mem_resp = 1'b1; #1;                          // t=5
    chk("t3_second_i_resp", i_dfp_resp, !first_is_i);
    chk("t3_second_d_resp", d_dfp_resp, first_is_i);
    cyc(); mem_resp = 1'b0; i_dfp_read = 1'b0; d_dfp_read = 1'b0; #1;
    chk("t3_done_idle", mem_read, 1'b0);

    // Test 4: both ports requesting continuously for 6 transactions
    cyc(); i_dfp_read = 1'b1; d_dfp_read = 1'b1;         // idle, grant at edge
    for (int k = 0; k < 6; k++) begin
`ifdef DFP_ARB_ROUND_ROBIN_EN
      exp_i = (k % 2 == 0);
`else
      exp_i = 1'b0;
`endif
      exp_addr = exp_i ? 32'h0000_0100 : 32'h0000_0200;
      cyc(); mem_resp = 1'b1; #1;
      chk($sformatf("t4_addr_%0d", k), mem_addr, exp_addr);
      chk($sformatf("t4_i_resp_%0d", k), i_dfp_resp, exp_i);
      chk($sformatf("t4_d_resp_%0d", k), d_dfp_resp, !exp_i);
      cyc(); mem_resp = 1'b0;
      if (k == 5) begin
        i_dfp_read = 1'b0; d_dfp_read = 1'b0;
      end
      #1; chk($sformatf("t4_idle_%0d", k), mem_read, 1'b0);
    end

    // Test 5: reset while BUSY_D, later mem_resp ignored
    cyc(); d_dfp_addr = 32'h0000_3000; d_dfp_read = 1'b1;
    cyc(); #1;
    chk("t5_busy_read", mem_read, 1'b1);
    chk("t5_busy_addr", mem_addr, 32'h0000_3000);
    rst = 1'b1; d_dfp_read = 1'b0;
    cyc(); rst = 1'b0; #1;
    chk("t5_rst_read", mem_read, 1'b0);
    chk("t5_rst_addr", mem_addr, 32'h0);
    cyc(); cyc(); mem_resp = 1'b1; #1;
    chk("t5_late_d_resp", d_dfp_resp, 1'b0);
    chk("t5_late_i_resp", i_dfp_resp, 1'b0);
    cyc(); mem_resp = 1'b0; #1;
    chk("t5_still_idle", mem_read, 1'b0);

    // Test 6: spurious mem_resp in IDLE, then a normal icache read
    cyc(); mem_resp = 1'b1; #1;
    chk("t6_spur_i_resp", i_dfp_resp, 1'b0);
    chk("t6_spur_d_resp", d_dfp_resp, 1'b0);
    cyc(); mem_resp = 1'b0; i_dfp_addr = 32'h0000_4000; i_dfp_read = 1'b1;
    cyc(); #1;
    chk("t6_read", mem_read, 1'b1);
    chk("t6_addr", mem_addr, 32'h0000_4000);
    cyc(); mem_resp = 1'b1; #1;
    chk("t6_i_resp", i_dfp_resp, 1'b1);
    cyc(); mem_resp = 1'b0; i_dfp_read = 1'b0; #1;
    chk("t6_done", mem_read, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
